// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index width for a requester count; never below one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side bus of the memory arbiter
interface mem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS-1:0]        req_valid;
  logic [NUM_MASTERS-1:0]        req_we;
  logic [NUM_MASTERS-1:0]        req_lock;
  logic [NUM_MASTERS*AW-1:0]     req_addr;
  logic [NUM_MASTERS*DW-1:0]     req_wdata;
  logic [NUM_MASTERS*DW/8-1:0]   req_be;
  logic [NUM_MASTERS-1:0]        req_ready;
  logic [NUM_MASTERS-1:0]        resp_valid;
  logic [DW-1:0]                 resp_rdata;
  logic                          mem_req;
  logic                          mem_we;
  logic [AW-1:0]                 mem_addr;
  logic [DW-1:0]                 mem_wdata;
  logic [DW/8-1:0]               mem_be;
  logic [DW-1:0]                 mem_rdata;
  logic                          mem_ready;

  // Arbiter view.
  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, req_be,
    input  mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requesters plus memory view.
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, req_be,
    output mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [N-1:0] eligible;

  assign eligible = req & mask;

  // Scan upward from start with wrap; the first eligible requester wins.
  always_comb begin
    int pos;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!valid && eligible[pos[IW-1:0]]) begin
        grant[pos[IW-1:0]] = 1'b1;
        idx                = pos[IW-1:0];
        valid              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin, lockable, non-pipelined single-port memory arbiter
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int IW = clog2(NUM_MASTERS);
  localparam int BW = DW / 8;

  state_t                 state;
  state_t                 state_nxt;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          last_idx;
  logic [IW-1:0]          lock_owner;
  logic                   locked;
  logic                   lat_we;
  logic [AW-1:0]          lat_addr;
  logic [DW-1:0]          lat_wdata;
  logic [BW-1:0]          lat_be;
  logic [NUM_MASTERS-1:0] resp_valid_q;
  logic [DW-1:0]          resp_rdata_q;

  logic [IW-1:0]          start_idx;
  logic [NUM_MASTERS-1:0] pick_mask;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   accept;

  // Round-robin resumes just past the last winner; a held lock admits only its owner.
  always_comb begin
    start_idx = (last_idx == IW'(NUM_MASTERS - 1)) ? '0 : last_idx + IW'(1);
    pick_mask = locked ? (NUM_MASTERS'(1) << lock_owner) : '1;
  end

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (bus.req_valid),
    .mask  (pick_mask),
    .start (start_idx),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign accept = (state == IDLE) && pick_valid && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: accept moves to BUSY, memory completion returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (bus.mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: accept pulse while idle, latched request driven while busy.
  always_comb begin
    bus.req_ready  = accept ? pick_grant : '0;
    bus.mem_req    = (state == BUSY);
    bus.mem_we     = (state == BUSY) && lat_we;
    bus.mem_addr   = lat_addr;
    bus.mem_wdata  = lat_wdata;
    bus.mem_be     = lat_be;
    bus.resp_valid = resp_valid_q;
    bus.resp_rdata = resp_rdata_q;
  end

  // Latch the winning request and produce the registered completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx    <= '0;
      last_idx     <= IW'(NUM_MASTERS - 1);
      lock_owner   <= '0;
      locked       <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= '0;
      if (accept) begin
        grant_idx  <= pick_idx;
        last_idx   <= pick_idx;
        lock_owner <= pick_idx;
        locked     <= bus.req_lock[pick_idx];
        lat_we     <= bus.req_we[pick_idx];
        lat_addr   <= bus.req_addr[pick_idx*AW +: AW];
        lat_wdata  <= bus.req_wdata[pick_idx*DW +: DW];
        lat_be     <= bus.req_be[pick_idx*BW +: BW];
      end
      if (state == BUSY && bus.mem_ready) begin
        resp_valid_q[grant_idx] <= 1'b1;
        if (!lat_we) resp_rdata_q <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk;
  logic rst;

  mem_arbiter_if #(.NUM_MASTERS(2), .AW(32), .DW(32)) bus ();

  mem_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory with programmable wait count.
  logic [31:0] mem [0:255];
  int          wait_cycles;
  int          cnt;
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_data;

  assign bus.mem_ready = bus.mem_req && (cnt == wait_cycles);
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  // Wait counter, preload port and byte-enabled write path.
  always @(posedge clk) begin
    if (rst || !bus.mem_req || bus.mem_ready) cnt <= 0;
    else cnt <= cnt + 1;
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (!rst && bus.mem_req && bus.mem_ready && bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
  end

  int total;
  int passed;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic set_master(input int m, input logic we, input logic lock,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus.req_we[m]              = we;
    bus.req_lock[m]            = lock;
    bus.req_addr[m*32 +: 32]   = addr;
    bus.req_wdata[m*32 +: 32]  = wdata;
    bus.req_be[m*4 +: 4]       = be;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_xact(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic ok);
    int n;
    ok = 1'b0; rdata = '0;
    @(negedge clk);
    set_master(m, we, 1'b0, addr, wdata, be);
    bus.req_valid[m] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[m] && n < 20) begin @(negedge clk); #1; n++; end
    if (bus.req_ready[m]) begin
      @(posedge clk); #1;
      bus.req_valid[m] = 1'b0;
      n = 0;
      while (!bus.resp_valid[m] && n < 20) begin @(posedge clk); #1; n++; end
      if (bus.resp_valid[m]) begin ok = 1'b1; rdata = bus.resp_rdata; end
    end else begin
      bus.req_valid[m] = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b11;
    @(negedge clk); #1;
    total++; if (bus.req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b exp 00", bus.req_ready); else passed++;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b exp 0", bus.mem_req); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b exp 0", bus.mem_we); else passed++;
    total++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h exp 0", bus.mem_addr); else passed++;
    total++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h exp 0", bus.mem_wdata); else passed++;
    total++; if (bus.mem_be !== 4'h0) $display("FAIL rst_mem_be: got %h exp 0", bus.mem_be); else passed++;
    total++; if (bus.resp_valid !== 2'b00) $display("FAIL rst_resp_valid: got %b exp 00", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata: got %h exp 0", bus.resp_rdata); else passed++;
    bus.req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    wait_cycles = 0;
    poke(8'd64, 32'hDEADBEEF);
    @(negedge clk);
    set_master(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL rd_accept: got %b exp 01", bus.req_ready); else passed++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    total++; if (bus.mem_req !== 1'b1) $display("FAIL rd_mem_req: got %b exp 1", bus.mem_req); else passed++;
    total++; if (bus.mem_addr !== 32'h100) $display("FAIL rd_mem_addr: got %h exp 100", bus.mem_addr); else passed++;
    total++; if (bus.resp_valid !== 2'b00) $display("FAIL rd_resp_early: got %b exp 00", bus.resp_valid); else passed++;
    @(posedge clk); #1;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL rd_mem_req_drop: got %b exp 0", bus.mem_req); else passed++;
    total++; if (bus.resp_valid !== 2'b01) $display("FAIL rd_resp_valid: got %b exp 01", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'hDEADBEEF) $display("FAIL rd_resp_rdata: got %h exp deadbeef", bus.resp_rdata); else passed++;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 2'b00) $display("FAIL rd_resp_pulse: got %b exp 00", bus.resp_valid); else passed++;
  endtask

  task automatic test_round_robin();
    int          ncnt;
    int          gcyc [4];
    logic [1:0]  gv   [4];
    logic [1:0]  exp_g;
    do_reset();
    wait_cycles = 1;
    ncnt = 0;
    @(negedge clk);
    set_master(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    set_master(1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.req_ready != 2'b00 && ncnt < 4) begin
        gv[ncnt] = bus.req_ready; gcyc[ncnt] = c; ncnt++;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    total++; if (ncnt !== 4) $display("FAIL rr_grant_count: got %0d exp 4", ncnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (i >= ncnt) $display("FAIL rr_grant_%0d: missing grant exp %b at cycle %0d", i, exp_g, 3*i);
      else if (gv[i] !== exp_g || gcyc[i] !== 3*i)
        $display("FAIL rr_grant_%0d: got %b at cycle %0d exp %b at cycle %0d", i, gv[i], gcyc[i], exp_g, 3*i);
      else passed++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_be();
    logic [31:0] rd;
    logic        ok;
    do_reset();
    wait_cycles = 0;
    poke(8'd16, 32'h0);
    @(negedge clk);
    set_master(1, 1'b1, 1'b0, 32'h40, 32'h12345678, 4'b0011);
    bus.req_valid = 2'b10;
    #1;
    total++; if (bus.req_ready !== 2'b10) $display("FAIL wr_accept: got %b exp 10", bus.req_ready); else passed++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    total++; if (bus.mem_req !== 1'b1) $display("FAIL wr_mem_req: got %b exp 1", bus.mem_req); else passed++;
    total++; if (bus.mem_we !== 1'b1) $display("FAIL wr_mem_we: got %b exp 1", bus.mem_we); else passed++;
    total++; if (bus.mem_be !== 4'b0011) $display("FAIL wr_mem_be: got %b exp 0011", bus.mem_be); else passed++;
    total++; if (bus.mem_wdata !== 32'h12345678) $display("FAIL wr_mem_wdata: got %h exp 12345678", bus.mem_wdata); else passed++;
    total++; if (bus.mem_addr !== 32'h40) $display("FAIL wr_mem_addr: got %h exp 40", bus.mem_addr); else passed++;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 2'b10) $display("FAIL wr_resp_valid: got %b exp 10", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL wr_rdata_kept: got %h exp 0", bus.resp_rdata); else passed++;
    run_xact(1, 1'b0, 32'h40, 32'h0, 4'hF, rd, ok);
    total++; if (ok !== 1'b1) $display("FAIL wr_readback_done: got %b exp 1", ok); else passed++;
    total++; if (rd !== 32'h00005678) $display("FAIL wr_readback_data: got %h exp 00005678", rd); else passed++;
  endtask

  task automatic test_lock();
    do_reset();
    wait_cycles = 0;
    @(negedge clk);
    set_master(0, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    set_master(1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL lk_first: got %b exp 01", bus.req_ready); else passed++;
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    total++; if (bus.req_ready !== 2'b00) $display("FAIL lk_busy: got %b exp 00", bus.req_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if (bus.req_ready !== 2'b00) $display("FAIL lk_stall_%0d: got %b exp 00", i, bus.req_ready); else passed++;
    end
    @(negedge clk);
    set_master(0, 1'b1, 1'b0, 32'h104, 32'hCAFEF00D, 4'hF);
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL lk_release_accept: got %b exp 01", bus.req_ready); else passed++;
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    total++; if (bus.req_ready !== 2'b00) $display("FAIL lk_release_busy: got %b exp 00", bus.req_ready); else passed++;
    @(negedge clk); #1;
    total++; if (bus.req_ready !== 2'b10) $display("FAIL lk_m1_next: got %b exp 10", bus.req_ready); else passed++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    wait_cycles = 3;
    @(negedge clk);
    set_master(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL rm_accept: got %b exp 01", bus.req_ready); else passed++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL rm_mem_req: got %b exp 0", bus.mem_req); else passed++;
    total++; if (bus.resp_valid !== 2'b00) $display("FAIL rm_resp_valid: got %b exp 00", bus.resp_valid); else passed++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00 || bus.mem_req) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL rm_abandoned: got %0d stray cycles exp 0", pulses); else passed++;
    @(negedge clk);
    set_master(1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL rm_first_grant: got %b exp 01", bus.req_ready); else passed++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_addr_stable();
    int busy;
    int bad;
    logic seen;
    logic [31:0] rd;
    do_reset();
    wait_cycles = 2;
    poke(8'd4, 32'hA5A50010);
    poke(8'd8, 32'h20202020);
    @(negedge clk);
    set_master(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL as_accept: got %b exp 01", bus.req_ready); else passed++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.req_addr[31:0] = 32'h20;
    busy = 0; bad = 0; seen = 1'b0; rd = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.mem_req) begin
        busy++;
        if (bus.mem_addr != 32'h10) bad++;
      end
      if (bus.resp_valid[0]) begin seen = 1'b1; rd = bus.resp_rdata; end
      else begin @(posedge clk); #1; end
    end
    total++; if (seen !== 1'b1) $display("FAIL as_resp_seen: got %b exp 1", seen); else passed++;
    total++; if (busy !== 3) $display("FAIL as_busy_cycles: got %0d exp 3", busy); else passed++;
    total++; if (bad !== 0) $display("FAIL as_addr_stable: got %0d wrong cycles exp 0", bad); else passed++;
    total++; if (rd !== 32'hA5A50010) $display("FAIL as_rdata: got %h exp a5a50010", rd); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    wait_cycles = 0;
    poke_en = 1'b0;
    poke_idx = '0;
    poke_data = '0;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_be = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_be();
    test_lock();
    test_reset_mid();
    test_addr_stable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory between NUM_MASTERS requesters, for example the core fetch/data ports or several cores in the multicore build. The arbiter is round-robin and non-pipelined: one outstanding transaction at a time. It supports a lock for atomic read-modify-write sequences. The memory side uses a req/ready handshake with variable latency.

Parameters:
NUM_MASTERS, 2, number of requesters; must be at least 2.
AW, 32, address width.
DW, 32, data width; byte enables are DW/8 wide.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  NUM_MASTERS  per-master request valid; held until req_ready.
req_we  input  NUM_MASTERS  per-master write enable.
req_lock  input  NUM_MASTERS  hold the grant for this master after this transaction.
req_addr  input  NUM_MASTERS*AW  packed addresses; master i occupies [i*AW +: AW].
req_wdata  input  NUM_MASTERS*DW  packed write data.
req_be  input  NUM_MASTERS*DW/8  packed byte enables.
req_ready  output  NUM_MASTERS  accept pulse, one-hot, combinational.
resp_valid  output  NUM_MASTERS  completion pulse, one-hot, registered.
resp_rdata  output  DW  read data; shared by all masters, valid with resp_valid.
mem_req  output  1  memory request.
mem_we  output  1  memory write enable.
mem_addr  output  AW  memory address.
mem_wdata  output  DW  memory write data.
mem_be  output  DW/8  memory byte enables.
mem_rdata  input  DW  memory read data; valid when mem_ready=1.
mem_ready  input  1  memory completion; may be high in the first cycle of mem_req.

Behaviour:
- States: IDLE, BUSY. Registers: state, grant_idx, last_idx, locked, lock_owner, latched request fields.
- Reset values: state=IDLE, last_idx=NUM_MASTERS-1, locked=0, and all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, resp_valid, resp_rdata). req_ready is 0 while rst=1.
- Reset is honoured in any state, including mid-transaction. An in-flight memory access is abandoned, and no resp_valid is issued for it.
- IDLE, locked=0:
  - Winner = first i with req_valid[i]=1, searching from (last_idx+1) mod NUM_MASTERS upward with wrap.
  - In the same cycle: req_ready[winner]=1; latch we/addr/wdata/be, grant_idx=winner, last_idx=winner, and locked/lock_owner from req_lock[winner]; go to BUSY.
- IDLE, locked=1: only lock_owner may win. Requests from other masters stall with req_ready=0 regardless of round-robin position.
- IDLE with no eligible request: stay in IDLE; all req_ready=0.
- BUSY:
  - mem_req=1 and the mem_* fields are driven from the latches, stable for the whole state.
  - All req_ready are 0.
  - On mem_ready=1: next cycle resp_valid[grant_idx]=1 for exactly one cycle, resp_rdata=mem_rdata for reads (writes leave resp_rdata unchanged), state returns to IDLE, and mem_req drops.
- Minimum transaction period is 2 cycles: accept cycle plus a BUSY cycle with mem_ready=1. A new accept may occur in the same cycle resp_valid is high.
- Lock release: locked clears when lock_owner issues a request with req_lock=0. That request still completes normally. After release, round-robin resumes from lock_owner+1.
- Lock owner stall: a master that set lock and then stops requesting keeps everyone else stalled. This is by design; software guarantees release.
- Fairness: with all masters continuously requesting, the grant order is 0,1,...,N-1,0,... after reset. Each master waits at most NUM_MASTERS-1 transactions when unlocked.
- Changes to req_* while req_ready=0 have no effect. Changes after acceptance do not affect the latched transaction.
- Latency from accept to resp_valid = 1 + (number of BUSY cycles).

Decomposition:
- Shared package: state encoding constants IDLE/BUSY, and a clog2 helper for the grant_idx width.
- One natural sub-module: rr_pick. It is a combinational round-robin priority picker taking a request vector, start index and mask, and producing a one-hot winner plus an index.
- Memory model for the bench: a mem_ready generator with a programmable wait count (0..3) over a behavioural array.

Test Plan:
- Reset then master 0 reads addr 0x100 (mem holds 0xDEADBEEF, 0 wait) -> req_ready[0] in accept cycle, mem_req for 1 cycle, resp_valid[0] and resp_rdata=0xDEADBEEF 2 cycles after accept.
- Both masters request continuously from reset with 1 wait state -> grants 0,1,0,1; each transaction 3 cycles; no master starved.
- Master 1 writes 0x12345678 with be=4'b0011 to 0x40 while master 0 idle -> mem_we=1, mem_be=0011; a readback returns 0x00005678 over an initial 0.
- Master 0 locked read then unlocked write, with master 1 requesting throughout -> master 1 receives no req_ready until master 0's unlocked write is accepted; master 1 wins next.
- rst asserted during BUSY with 3 wait states -> next cycle mem_req=0, resp_valid=0, state IDLE; the subsequent grant goes to master 0 first.
- Requester changes req_addr from 0x10 to 0x20 during BUSY -> mem_addr stays 0x10 until completion.
